// File: rtl/uart_tx_feeder.sv
// Queues producer frames in a circular buffer and hands them one at a time to a
// UART transmitter, waiting for a fresh tx_done rising edge before the next frame.
module uart_tx_feeder #(
  parameter int FRAME_WD = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_WD  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [FRAME_WD-1:0] wr_data,
  input  logic                tx_done,
  output logic                frame_en,
  output logic [FRAME_WD-1:0] data_frame,
  output logic                full,
  output logic                empty,
  output logic [ADDR_WD:0]    count,
  output logic                busy,
  output logic                overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE
  } state_e;

  localparam logic [ADDR_WD:0] DEPTH_CNT = (ADDR_WD+1)'(DEPTH);
  localparam logic [ADDR_WD:0] CNT_ONE   = (ADDR_WD+1)'(1);
  localparam logic [ADDR_WD-1:0] PTR_ONE = ADDR_WD'(1);

  logic [FRAME_WD-1:0] mem [DEPTH];

  state_e              state_q, state_d;
  logic [ADDR_WD-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WD-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_WD:0]    count_q, count_d;
  logic [FRAME_WD-1:0] data_frame_q, data_frame_d;
  logic                frame_en_q, frame_en_d;
  logic                overflow_q, overflow_d;
  logic                tx_done_dly_q;

  logic full_c;
  logic empty_c;
  logic push_c;
  logic pop_c;
  logic tx_rise_c;

  // Flags come from the registered count, so a write into an empty FIFO is
  // only visible to the FSM on the following cycle.
  assign full_c    = (count_q == DEPTH_CNT);
  assign empty_c   = (count_q == '0);
  assign push_c    = wr_en && !full_c;
  assign pop_c     = (state_q == S_IDLE) && !empty_c;
  assign tx_rise_c = tx_done && !tx_done_dly_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    frame_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_c) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d    = S_START;
        frame_en_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_rise_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_frame_d = data_frame_q;
    overflow_d   = wr_en && full_c;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_c) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      data_frame_d = mem[rd_ptr_q];
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      data_frame_q  <= '0;
      frame_en_q    <= 1'b0;
      overflow_q    <= 1'b0;
      tx_done_dly_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_frame_q  <= data_frame_d;
      frame_en_q    <= frame_en_d;
      overflow_q    <= overflow_d;
      tx_done_dly_q <= tx_done;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, so clearing it would only cost a reset tree.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) mem[wr_ptr_q] <= wr_data;
  end

  assign frame_en   = frame_en_q;
  assign data_frame = data_frame_q;
  assign full       = full_c;
  assign empty      = empty_c;
  assign count      = count_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus random traffic,
// compared every cycle against a queue-and-timestamp reference model.
module tb_uart_tx_feeder;

  localparam int FRAME_WD = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_WD  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en;
  logic [FRAME_WD-1:0] wr_data;
  logic                tx_done;
  logic                frame_en;
  logic [FRAME_WD-1:0] data_frame;
  logic                full;
  logic                empty;
  logic [ADDR_WD:0]    count;
  logic                busy;
  logic                overflow;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .FRAME_WD(FRAME_WD),
    .DEPTH   (DEPTH),
    .ADDR_WD (ADDR_WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .tx_done   (tx_done),
    .frame_en  (frame_en),
    .data_frame(data_frame),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .busy      (busy),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_frames = 0;

  // Reference model: queued frames, the frame in flight and when it was popped.
  logic [FRAME_WD-1:0] m_q[$];
  bit                  m_busy;
  int                  m_pop_cyc;
  logic [FRAME_WD-1:0] m_cur;
  bit                  m_ovf;
  bit                  m_txd_prev;
  bit                  td_lvl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy     = 1'b0;
    m_pop_cyc  = -10;
    m_cur      = '0;
    m_ovf      = 1'b0;
    m_txd_prev = 1'b0;
  endtask

  // Check the current cycle's outputs, apply this cycle's inputs, advance the
  // model across the coming edge, then move to 1 time unit after that edge.
  task automatic step(input bit we, input logic [FRAME_WD-1:0] d, input bit td, input bit rst_ok);
    int  sz;
    bit  exp_fe;
    bit  pop;
    bit  done;
    sz     = m_q.size();
    exp_fe = m_busy && (cyc == m_pop_cyc + 2);
    check("frame_en",   {31'b0, frame_en}, {31'b0, exp_fe});
    check("data_frame", 32'(data_frame), 32'(m_cur));
    check("busy",       {31'b0, busy}, {31'b0, m_busy});
    check("count",      32'(count), 32'(sz));
    check("full",       {31'b0, full}, {31'b0, (sz == DEPTH)});
    check("empty",      {31'b0, empty}, {31'b0, (sz == 0)});
    check("overflow",   {31'b0, overflow}, {31'b0, m_ovf});
    if (frame_en === 1'b1) n_frames++;

    rst_n   = rst_ok;
    wr_en   = we;
    wr_data = d;
    tx_done = td;
    td_lvl  = td;

    if (!rst_ok) begin
      model_reset();
    end else begin
      // Pop only from an idle, non-empty queue; completion needs a fresh rise
      // of tx_done once the frame has been started (3 cycles after the pop).
      pop   = !m_busy && (sz > 0);
      done  = m_busy && (cyc >= m_pop_cyc + 3) && td && !m_txd_prev;
      m_ovf = we && (sz == DEPTH);
      if (pop) begin
        m_cur     = m_q.pop_front();
        m_busy    = 1'b1;
        m_pop_cyc = cyc;
      end
      if (done) m_busy = 1'b0;
      if (we && (sz < DEPTH)) m_q.push_back(d);
      m_txd_prev = td;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit td);
    for (int i = 0; i < n; i++) step(1'b0, '0, td, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    tx_done = 1'b0;
    td_lvl  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with wr_en asserted to show it is ignored under reset.
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Single frame: frame_en three cycles after the write, completion on tx_done rise.
    step(1'b1, 8'h2B, 1'b0, 1'b1);
    idle(24, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(6, 1'b0);

    // Burst of three with tx_done pulsed about 20 cycles after each start.
    step(1'b1, 8'h2B, 1'b0, 1'b1);
    step(1'b1, 8'h35, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(20, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
    end
    idle(8, 1'b0);

    // Fill with tx_done low: 17 writes accepted, the 18th overflows.
    for (int k = 0; k < 18; k++) step(1'b1, FRAME_WD'($urandom), 1'b0, 1'b1);
    idle(4, 1'b0);
    for (int k = 0; k < 20; k++) begin
      idle(4, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
    end
    idle(6, 1'b0);

    // Stuck-high tx_done across a frame start must not complete it.
    step(1'b1, 8'h5C, 1'b1, 1'b1);
    idle(12, 1'b1);
    idle(3, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(6, 1'b0);

    // Reset in WAIT_DONE with three entries queued.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    idle(5, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    idle(10, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    idle(8, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(4, 1'b0);

    // Random traffic: a heavy phase that hits full/overflow, then a light one
    // that drains; tx_done toggles randomly in every FSM state.
    for (int k = 0; k < 2400; k++) begin
      bit we;
      bit td;
      we = (k < 1200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      td = ($urandom_range(0, 2) == 0) ? !td_lvl : td_lvl;
      step(we, FRAME_WD'($urandom), td, 1'b1);
    end
    for (int k = 0; k < 30; k++) begin
      idle(4, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
    end
    idle(4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
